// File: rtl/cpu_defs.sv
// Shared CPU definitions for the write-back slice.
// - ld_type_e : 3-bit load-type codes carried down the pipe (LT_NONE for non-loads)
// - BE_*      : register-file byte-enable constants
// - ws_payload_t : instruction fields latched by the write-back stage
// - be_mask() : expands a 4-bit byte enable into a 32-bit lane mask
package cpu_defs;

  typedef enum logic [2:0] {
    LT_NONE = 3'd0,
    LT_LB   = 3'd1,
    LT_LBU  = 3'd2,
    LT_LH   = 3'd3,
    LT_LHU  = 3'd4,
    LT_LW   = 3'd5,
    LT_LWL  = 3'd6,
    LT_LWR  = 3'd7
  } ld_type_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] result;
    logic [31:0] rdata;
    logic [31:0] rt_old;
  } ws_payload_t;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: turns a load type, the low address bits and
// the raw memory word into register-file byte enables and lane-positioned data.
// - ld_type : load-type code (cpu_defs::ld_type_e)
// - addr_lo : data address [1:0]
// - rdata   : raw aligned memory word
// - result  : ALU result, used for non-loads
// - be      : byte enables for the destination register
// - data    : write data; lanes outside be are 0
module load_align
  import cpu_defs::*;
(
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] result,
  output logic [3:0]  be,
  output logic [31:0] data
);

  logic [7:0]  byte_k;
  logic [15:0] half_k;

  assign byte_k = rdata[{addr_lo, 3'b000} +: 8];
  assign half_k = rdata[{addr_lo[1], 4'b0000} +: 16];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    be   = BE_ALL;
    data = '0;
    unique case (ld_type_e'(ld_type))
      LT_NONE: data = result;
      LT_LW:   data = rdata;
      LT_LB:   data = {{24{byte_k[7]}}, byte_k};
      LT_LBU:  data = {24'b0, byte_k};
      LT_LH:   data = {{16{half_k[15]}}, half_k};
      LT_LHU:  data = {16'b0, half_k};
      // LWL: the low k+1 memory bytes land in the top lanes of rt.
      LT_LWL: begin
        data = rdata << {~addr_lo, 3'b000};
        be   = BE_ALL << ~addr_lo;
      end
      // LWR: the high 4-k memory bytes land in the bottom lanes of rt.
      LT_LWR: begin
        data = rdata >> {addr_lo, 3'b000};
        be   = BE_ALL >> addr_lo;
      end
      default: data = result;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: sole producer of register-file writes.
// Latches one instruction from the memory stage, aligns/extends load data and
// issues a byte-enable write so LWL/LWR merge without read-modify-write.
// Ports:
// - clk, reset              : clock, synchronous active-high reset
// - ms_to_ws_valid / ws_allowin : handshake with the memory stage
// - ms_*                    : instruction payload from the memory stage
// - ws_stall, ws_flush      : hold current instruction / drop it (exception, eret)
// - rf_we/rf_waddr/rf_wdata : register-file write port (byte enables)
// - ws_fwd_*                : bypass entry for the ID stage (ignores stall)
// - debug_wb_*              : NSCSCC trace; wdata is the merged full word
module wb_stage
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [2:0]  ms_ld_type,
  input  logic [1:0]  ms_addr_lo,
  input  logic [31:0] ms_result,
  input  logic [31:0] ms_rdata,
  input  logic [31:0] ms_rt_old,
  input  logic        ws_stall,
  input  logic        ws_flush,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_fwd_valid,
  output logic [4:0]  ws_fwd_addr,
  output logic [3:0]  ws_fwd_be,
  output logic [31:0] ws_fwd_data,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        ws_valid;
  ws_payload_t pl;
  logic        ws_ready_go;
  logic        writes_gpr;
  logic        fire;
  logic [3:0]  al_be;
  logic [31:0] al_data;
  logic [31:0] al_mask;

  assign ws_ready_go = !ws_stall;
  assign ws_allowin  = !ws_valid || ws_ready_go;

  // NOTE: sequential state uses non-blocking assignments only. The payload is
  // reset too (not just ws_valid) so every output, including trace and bypass
  // fields, reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
      pl       <= '0;
    end else begin
      if (ws_flush)
        ws_valid <= 1'b0;
      else if (ws_allowin)
        ws_valid <= ms_to_ws_valid;

      if (!ws_flush && ws_allowin && ms_to_ws_valid) begin
        pl.pc      <= ms_pc;
        pl.gr_we   <= ms_gr_we;
        pl.dest    <= ms_dest;
        pl.ld_type <= ms_ld_type;
        pl.addr_lo <= ms_addr_lo;
        pl.result  <= ms_result;
        pl.rdata   <= ms_rdata;
        pl.rt_old  <= ms_rt_old;
      end
    end
  end

  load_align u_load_align (
    .ld_type (pl.ld_type),
    .addr_lo (pl.addr_lo),
    .rdata   (pl.rdata),
    .result  (pl.result),
    .be      (al_be),
    .data    (al_data)
  );

  // $0 is never written; the bypass stays visible while stalled so ID can
  // still pick up the pending value.
  assign writes_gpr = ws_valid && pl.gr_we && (pl.dest != 5'd0);
  assign fire       = writes_gpr && ws_ready_go;
  assign al_mask    = be_mask(al_be);

  assign rf_we    = fire ? al_be : BE_NONE;
  assign rf_waddr = pl.dest;
  assign rf_wdata = al_data;

  assign ws_fwd_valid = writes_gpr;
  assign ws_fwd_addr  = writes_gpr ? pl.dest : 5'd0;
  assign ws_fwd_be    = writes_gpr ? al_be   : BE_NONE;
  assign ws_fwd_data  = writes_gpr ? al_data : 32'd0;

  assign debug_wb_pc       = pl.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = pl.dest;
  assign debug_wb_rf_wdata = (pl.rt_old & ~al_mask) | (al_data & al_mask);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a driver issues directed then random
// cycles, a byte-level reference model pushes the expected per-cycle outputs
// into a queue, and a monitor pops and compares them against the DUT.
module tb_wb_stage;
  import cpu_defs::*;

  typedef struct {
    logic        gr_we;
    logic [4:0]  dest;
    logic [2:0]  lt;
    logic [1:0]  k;
    logic [31:0] result;
    logic [31:0] rdata;
    logic [31:0] rt_old;
    logic [31:0] pc;
  } instr_t;

  typedef struct {
    logic        allowin;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] trace;
    logic [31:0] pc;
    logic        fwd_valid;
    logic [3:0]  fwd_be;
    logic [31:0] fwd_data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [2:0]  ms_ld_type;
  logic [1:0]  ms_addr_lo;
  logic [31:0] ms_result;
  logic [31:0] ms_rdata;
  logic [31:0] ms_rt_old;
  logic        ws_stall;
  logic        ws_flush;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_addr;
  logic [3:0]  ws_fwd_be;
  logic [31:0] ws_fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int errors = 0;

  exp_t   exp_q[$];
  logic   m_valid;
  instr_t m_ins;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ws_allowin        (ws_allowin),
    .ms_pc             (ms_pc),
    .ms_gr_we          (ms_gr_we),
    .ms_dest           (ms_dest),
    .ms_ld_type        (ms_ld_type),
    .ms_addr_lo        (ms_addr_lo),
    .ms_result         (ms_result),
    .ms_rdata          (ms_rdata),
    .ms_rt_old         (ms_rt_old),
    .ws_stall          (ws_stall),
    .ws_flush          (ws_flush),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_valid      (ws_fwd_valid),
    .ws_fwd_addr       (ws_fwd_addr),
    .ws_fwd_be         (ws_fwd_be),
    .ws_fwd_data       (ws_fwd_data),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int j = 0; j < 4; j++)
      if (be[j]) m[8*j +: 8] = 8'hFF;
    return m;
  endfunction

  // Reference: pick memory bytes by index and place them lane by lane.
  function automatic void ref_load(input instr_t i, output logic [3:0] be,
                                   output logic [31:0] data, output logic [31:0] trace);
    logic [7:0]  b[4];
    logic [15:0] h;
    int          k;
    int          kk;
    for (int j = 0; j < 4; j++) b[j] = i.rdata[8*j +: 8];
    k    = int'(i.k);
    kk   = k & 2;
    h    = {b[kk+1], b[kk]};
    be   = 4'b1111;
    data = '0;
    case (i.lt)
      LT_NONE: data = i.result;
      LT_LW:   data = i.rdata;
      LT_LB:   data = {{24{b[k][7]}}, b[k]};
      LT_LBU:  data = {24'd0, b[k]};
      LT_LH:   data = {{16{h[15]}}, h};
      LT_LHU:  data = {16'd0, h};
      LT_LWL: begin
        be = 4'b0000;
        for (int j = 0; j < 4; j++)
          if (j >= 3 - k) begin
            be[j] = 1'b1;
            data[8*j +: 8] = b[j - (3 - k)];
          end
      end
      default: begin // LT_LWR
        be = 4'b0000;
        for (int j = 0; j < 4; j++)
          if (j <= 3 - k) begin
            be[j] = 1'b1;
            data[8*j +: 8] = b[j + k];
          end
      end
    endcase
    trace = i.rt_old;
    for (int j = 0; j < 4; j++)
      if (be[j]) trace[8*j +: 8] = data[8*j +: 8];
  endfunction

  function automatic instr_t mk(input logic gr_we, input logic [4:0] dest, input logic [2:0] lt,
                                input logic [1:0] k, input logic [31:0] result,
                                input logic [31:0] rdata, input logic [31:0] rt_old,
                                input logic [31:0] pc);
    instr_t i;
    i.gr_we = gr_we; i.dest = dest; i.lt = lt; i.k = k;
    i.result = result; i.rdata = rdata; i.rt_old = rt_old; i.pc = pc;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.gr_we  = ($urandom_range(9) != 0);
    i.dest   = 5'($urandom);
    i.lt     = 3'($urandom);
    i.k      = 2'($urandom);
    if (i.lt == LT_LH || i.lt == LT_LHU) i.k[0] = 1'b0;
    i.result = $urandom;
    i.rdata  = $urandom;
    i.rt_old = $urandom;
    i.pc     = {$urandom_range(32'h3FFF_FFFF), 2'b00};
    return i;
  endfunction

  // One clock cycle: drive inputs, record what the stage must show this cycle,
  // then advance the model across the coming edge.
  task automatic step(input bit rst, input bit v, input bit st, input bit fl, input instr_t ins);
    exp_t        e;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] trace;
    bit          wr;
    @(negedge clk);
    reset = rst; ms_to_ws_valid = v; ws_stall = st; ws_flush = fl;
    ms_pc = ins.pc; ms_gr_we = ins.gr_we; ms_dest = ins.dest; ms_ld_type = ins.lt;
    ms_addr_lo = ins.k; ms_result = ins.result; ms_rdata = ins.rdata; ms_rt_old = ins.rt_old;

    ref_load(m_ins, be, data, trace);
    wr          = m_valid && m_ins.gr_we && (m_ins.dest != 0);
    e.allowin   = !m_valid || !st;
    e.we        = (wr && !st) ? be : 4'b0000;
    e.waddr     = m_ins.dest;
    e.wdata     = data;
    e.trace     = trace;
    e.pc        = m_ins.pc;
    e.fwd_valid = wr;
    e.fwd_be    = be;
    e.fwd_data  = data;
    exp_q.push_back(e);

    if (rst) begin
      m_valid = 1'b0;
      m_ins   = mk(0, 0, LT_NONE, 0, 0, 0, 0, 0);
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (e.allowin) begin
      m_valid = v;
      if (v) m_ins = ins;
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ws_allowin", 32'(ws_allowin), 32'(e.allowin));
        check("rf_we", 32'(rf_we), 32'(e.we));
        check("trace_wen", 32'(debug_wb_rf_wen), 32'(e.we));
        check("trace_pc", debug_wb_pc, e.pc);
        check("fwd_valid", 32'(ws_fwd_valid), 32'(e.fwd_valid));
        if (e.we != 4'b0000) begin
          check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
          check("trace_wnum", 32'(debug_wb_rf_wnum), 32'(e.waddr));
          check("rf_wdata", rf_wdata & lane_mask(e.we), e.wdata & lane_mask(e.we));
          check("trace_wdata", debug_wb_rf_wdata, e.trace);
        end
        if (e.fwd_valid) begin
          check("fwd_addr", 32'(ws_fwd_addr), 32'(e.waddr));
          check("fwd_be", 32'(ws_fwd_be), 32'(e.fwd_be));
          check("fwd_data", ws_fwd_data & lane_mask(e.fwd_be), e.fwd_data & lane_mask(e.fwd_be));
        end
      end
    end
  end

  initial begin
    instr_t nop;
    nop = mk(0, 0, LT_NONE, 0, 0, 0, 0, 0);
    m_valid = 1'b0;
    m_ins   = nop;
    reset = 1'b1; ms_to_ws_valid = 1'b0; ws_stall = 1'b0; ws_flush = 1'b0;
    ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0; ms_ld_type = '0; ms_addr_lo = '0;
    ms_result = '0; ms_rdata = '0; ms_rt_old = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_allowin", 32'(ws_allowin), 32'd1);
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    check("reset_rf_wdata", rf_wdata, 32'd0);
    check("reset_fwd", {ws_fwd_data[25:0], ws_fwd_be, ws_fwd_addr[0], ws_fwd_valid}, 32'd0);
    check("reset_fwd_addr", 32'(ws_fwd_addr), 32'd0);
    check("reset_trace_pc", debug_wb_pc, 32'd0);
    check("reset_trace_wen", 32'(debug_wb_rf_wen), 32'd0);
    check("reset_trace_wnum", 32'(debug_wb_rf_wnum), 32'd0);
    check("reset_trace_wdata", debug_wb_rf_wdata, 32'd0);

    // Plain ALU write, then the load alignment cases.
    step(0, 1, 0, 0, mk(1, 5, LT_NONE, 0, 32'h1234_5678, 0, 0, 32'hBFC0_0000));
    step(0, 1, 0, 0, mk(1, 6, LT_LB, 3, 0, 32'h80FF_0000, 0, 32'hBFC0_0004));
    step(0, 1, 0, 0, mk(1, 7, LT_LBU, 3, 0, 32'h80FF_0000, 0, 32'hBFC0_0008));
    step(0, 1, 0, 0, mk(1, 8, LT_LH, 2, 0, 32'h80FF_0000, 0, 32'hBFC0_000C));
    step(0, 1, 0, 0, mk(1, 9, LT_LWL, 1, 0, 32'hAABB_CCDD, 32'h1122_3344, 32'hBFC0_0010));
    step(0, 1, 0, 0, mk(1, 10, LT_LWR, 2, 0, 32'hAABB_CCDD, 32'h1122_3344, 32'hBFC0_0014));
    // $0 destination: no write, no bypass.
    step(0, 1, 0, 0, mk(1, 0, LT_NONE, 0, 32'hDEAD_BEEF, 0, 0, 32'hBFC0_0018));
    step(0, 0, 0, 0, nop);
    // Stall a valid LW for three cycles, then release.
    step(0, 1, 0, 0, mk(1, 11, LT_LW, 0, 0, 32'hCAFE_F00D, 0, 32'hBFC0_001C));
    step(0, 1, 1, 0, mk(1, 12, LT_NONE, 0, 32'h5555_AAAA, 0, 0, 32'hBFC0_0020));
    step(0, 1, 1, 0, mk(1, 12, LT_NONE, 0, 32'h5555_AAAA, 0, 0, 32'hBFC0_0020));
    step(0, 1, 1, 0, mk(1, 12, LT_NONE, 0, 32'h5555_AAAA, 0, 0, 32'hBFC0_0020));
    step(0, 0, 0, 0, nop);
    step(0, 0, 0, 0, nop);
    // Flush with a new instruction offered while a stalled one is held.
    step(0, 1, 0, 0, mk(1, 13, LT_LW, 0, 0, 32'h0BAD_0BAD, 0, 32'hBFC0_0024));
    step(0, 1, 1, 1, mk(1, 14, LT_NONE, 0, 32'h7777_7777, 0, 0, 32'hBFC0_0028));
    step(0, 0, 0, 0, nop);
    // Flush without stall: the held write still commits in the flush cycle.
    step(0, 1, 0, 0, mk(1, 15, LT_LHU, 2, 0, 32'hF00D_1234, 0, 32'hBFC0_002C));
    step(0, 1, 0, 1, mk(1, 16, LT_NONE, 0, 32'h8888_8888, 0, 0, 32'hBFC0_0030));
    step(0, 0, 0, 0, nop);
    // Reset while a stalled instruction is held: dropped, no write.
    step(0, 1, 0, 0, mk(1, 17, LT_LW, 0, 0, 32'h1357_9BDF, 0, 32'hBFC0_0034));
    step(0, 0, 1, 0, nop);
    step(1, 0, 1, 0, nop);
    step(0, 0, 0, 0, nop);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(49) == 0), ($urandom_range(9) < 7), ($urandom_range(9) < 3),
           ($urandom_range(9) == 0), rand_instr());
    end
    step(0, 0, 0, 0, nop);

    repeat (2) @(negedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
